// File: rtl/beamscaler_pkg.sv
// beamscaler_pkg: shared constants, FSM state type and sizing helper for the beam-scaler readout
package beamscaler_pkg;
    localparam logic [7:0] BSR_HDR_MAGIC   = 8'hBC;
    localparam logic [7:0] BSR_SUBTHR_BASE = 8'h80;
    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_READ_LO, S_READ_HI, S_DRAIN} bsr_state_t;
    function automatic int bsr_nwords(input int nbeams);
        return (nbeams + 1) / 2;
    endfunction
endpackage

// File: rtl/bsr_sync_fifo.sv
// bsr_sync_fifo: show-ahead synchronous FIFO with occupancy count; output reads zero while empty
module bsr_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic [W-1:0]               dout_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;
    assign do_pop  = pop_i && cnt_q != '0;
    assign do_push = push_i && (cnt_q != FULL || do_pop);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
    assign dout_o  = cnt_q == '0 ? '0 : mem_q[rd_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/beamscaler_readout.sv
// beamscaler_readout: per-update AXI4-Stream frame reader for the double-banked beam-scaler RAM
// Optional header word (seq/overrun) enabled by BEAMSCALER_READOUT_HEADER_EN.
module beamscaler_readout
    import beamscaler_pkg::*;
#(
    parameter int NBEAMS     = 2,
    parameter int SETTLE     = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        done_i,
    output logic        scal_rd_o,
    output logic [7:0]  scal_adr_o,
    input  logic [31:0] scal_dat_i,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        busy_o
);
    localparam int NWORDS = bsr_nwords(NBEAMS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] LAST_W = 8'(NWORDS - 1);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
    bsr_state_t  state_q, state_d;
    logic [3:0]  settle_q, settle_d;
    logic [7:0]  word_q, word_d;
    logic        rd1_q, rd2_q, last1_q, last2_q;
    logic [CW-1:0] fifo_cnt;
    logic [1:0]  inflight;
    logic        credit, reading, last_rd, hdr_push;
    logic [31:0] hdr_dat;
    logic [32:0] fifo_dout;
`ifdef BEAMSCALER_READOUT_HEADER_EN
    logic [15:0] seq_q, seq_d;
    logic [7:0]  ovr_q, ovr_d;
    always_comb begin
        seq_d = (done_i && state_q == S_IDLE) ? seq_q + 16'd1 : seq_q;
        ovr_d = (done_i && state_q != S_IDLE && ovr_q != 8'hFF) ? ovr_q + 8'd1 : ovr_q;
    end
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            seq_q <= '0;
            ovr_q <= '0;
        end else begin
            seq_q <= seq_d;
            ovr_q <= ovr_d;
        end
    end
    assign hdr_push = done_i && state_q == S_IDLE;
    assign hdr_dat  = {BSR_HDR_MAGIC, ovr_q, seq_q + 16'd1};
`else
    assign hdr_push = 1'b0;
    assign hdr_dat  = '0;
`endif
    // Credit covers words already queued plus reads still in the 2-cycle RAM pipe, so the FIFO never overflows.
    assign inflight  = {1'b0, rd1_q} + {1'b0, rd2_q};
    assign credit    = ({1'b0, fifo_cnt} + {{(CW-1){1'b0}}, inflight}) < DEPTH_C;
    assign reading   = state_q == S_READ_LO || state_q == S_READ_HI;
    assign scal_rd_o = reading && credit;
    assign scal_adr_o = state_q == S_READ_HI ? (BSR_SUBTHR_BASE | word_q) : word_q;
    assign last_rd   = scal_rd_o && state_q == S_READ_HI && word_q == LAST_W;
    assign busy_o    = state_q != S_IDLE;
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        word_d   = word_q;
        case (state_q)
            S_IDLE: if (done_i) begin
                state_d  = S_SETTLE;
                settle_d = 4'(SETTLE - 1);
            end
            S_SETTLE: if (settle_q == '0) state_d = S_READ_LO; else settle_d = settle_q - 4'd1;
            S_READ_LO: if (scal_rd_o) begin
                word_d  = word_q == LAST_W ? '0 : word_q + 8'd1;
                state_d = word_q == LAST_W ? S_READ_HI : S_READ_LO;
            end
            S_READ_HI: if (scal_rd_o) begin
                word_d  = word_q == LAST_W ? '0 : word_q + 8'd1;
                state_d = word_q == LAST_W ? S_DRAIN : S_READ_HI;
            end
            S_DRAIN: if (fifo_cnt == '0 && !rd1_q && !rd2_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            settle_q <= '0;
            word_q   <= '0;
            rd1_q    <= 1'b0;
            rd2_q    <= 1'b0;
            last1_q  <= 1'b0;
            last2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            word_q   <= word_d;
            rd1_q    <= scal_rd_o;
            rd2_q    <= rd1_q;
            last1_q  <= last_rd;
            last2_q  <= last1_q;
        end
    end
    bsr_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(33)) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (hdr_push || rd2_q),
        .din_i   (rd2_q ? {last2_q, scal_dat_i} : {1'b0, hdr_dat}),
        .pop_i   (m_axis_tready),
        .dout_o  (fifo_dout),
        .count_o (fifo_cnt)
    );
    assign m_axis_tvalid = fifo_cnt != '0;
    assign m_axis_tdata  = fifo_dout[31:0];
    assign m_axis_tlast  = fifo_dout[32];
endmodule

// File: tb/tb_beamscaler_readout.sv
// tb_beamscaler_readout: directed stimulus with a frame-level scoreboard model and literal header checks
module tb_beamscaler_readout;
`ifdef BEAMSCALER_READOUT_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif
    localparam int NW5 = 3;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    int errors = 0, checks = 0;
    logic done2 = 1'b0, tready2 = 1'b1, rd2, tvalid2, tlast2, busy2;
    logic [7:0] adr2;
    logic [31:0] tdata2, s1_2 = '0, s2_2 = '0;
    logic done5 = 1'b0, tready5 = 1'b1, rd5, tvalid5, tlast5, busy5;
    logic [7:0] adr5;
    logic [31:0] tdata5, s1_5 = '0, s2_5 = '0;

    beamscaler_readout #(.NBEAMS(2), .SETTLE(3), .FIFO_DEPTH(4)) u2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .done_i(done2), .scal_rd_o(rd2), .scal_adr_o(adr2),
        .scal_dat_i(s2_2), .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2), .m_axis_tready(tready2),
        .m_axis_tlast(tlast2), .busy_o(busy2));
    beamscaler_readout #(.NBEAMS(5), .SETTLE(3), .FIFO_DEPTH(4)) u5 (
        .wb_clk_i(clk), .wb_rst_i(rst), .done_i(done5), .scal_rd_o(rd5), .scal_adr_o(adr5),
        .scal_dat_i(s2_5), .m_axis_tdata(tdata5), .m_axis_tvalid(tvalid5), .m_axis_tready(tready5),
        .m_axis_tlast(tlast5), .busy_o(busy5));

    function automatic logic [31:0] mem2(input logic [7:0] a);
        return a == 8'h00 ? 32'h0ABC0123 : a == 8'h80 ? 32'h00050FFF : 32'h0;
    endfunction
    function automatic logic [31:0] mem5(input logic [7:0] a);
        return {a, ~a, 8'h3C, a ^ 8'h5A};
    endfunction

    // RAM models: data appears two cycles after the read, garbage otherwise
    always @(posedge clk) begin
        s1_2 <= rd2 ? mem2(adr2) : 32'hDEADBEEF;
        s2_2 <= s1_2;
        s1_5 <= rd5 ? mem5(adr5) : 32'hDEADBEEF;
        s2_5 <= s1_5;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Frame-level model of u5: expected word queue, read address order, seq/overrun counters
    logic [32:0] expq[$];
    logic [15:0] m_seq = '0;
    logic [7:0]  m_ovr = '0;
    bit          m_active = 1'b0;
    int          m_rdi = 0;
    logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [31:0] pd = '0;
    always @(negedge clk) begin
        #1;
        if (rst) begin
            expq.delete();
            m_seq = '0;
            m_ovr = '0;
            m_active = 1'b0;
            m_rdi = 0;
            pv = 1'b0;
        end else begin
            if (pv && !pr) check("axi_hold", {tvalid5, tlast5, tdata5}, {1'b1, pl, pd});
            if (tvalid5) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_word: got %h expected none", {tlast5, tdata5});
                end else begin
                    check("stream", {tlast5, tdata5}, expq[0]);
                    if (tready5) begin
                        if (expq[0][32]) m_active = 1'b0;
                        void'(expq.pop_front());
                    end
                end
            end
            if (rd5) begin
                if (m_rdi >= 2 * NW5) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_read: got adr %h expected no read", adr5);
                end else check("rd_adr", adr5, m_rdi < NW5 ? 8'(m_rdi) : 8'(m_rdi - NW5) | 8'h80);
                m_rdi++;
            end
            if (done5) begin
                if (m_active) m_ovr = m_ovr == 8'hFF ? 8'hFF : m_ovr + 8'd1;
                else begin
                    m_active = 1'b1;
                    m_seq = m_seq + 16'd1;
                    m_rdi = 0;
                    if (HDR) expq.push_back({1'b0, 8'hBC, m_ovr, m_seq});
                    for (int i = 0; i < 2 * NW5; i++)
                        expq.push_back({i == 2 * NW5 - 1, mem5(i < NW5 ? 8'(i) : 8'(i - NW5) | 8'h80)});
                end
            end
            pv = tvalid5;
            pr = tready5;
            pl = tlast5;
            pd = tdata5;
        end
    end

    logic [32:0] q2[$];
    always @(negedge clk) begin
        #1;
        if (rst) q2.delete();
        else if (tvalid2 && tready2) q2.push_back({tlast2, tdata2});
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (m_active && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (m_active) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got busy expected frame end", name);
        end
        repeat (4) @(negedge clk);
        check({name, "_busy_end"}, busy5, 0);
    endtask

    task automatic pulse5();
        done5 = 1'b1;
        @(negedge clk);
        done5 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] e2[$];
        int n;
        repeat (3) @(negedge clk);
        check("rst_rd", {rd2, rd5}, 0);
        check("rst_adr", {adr2, adr5}, 0);
        check("rst_tvalid", {tvalid2, tvalid5}, 0);
        check("rst_tlast", {tlast2, tlast5}, 0);
        check("rst_tdata", {tdata2, tdata5}, 0);
        check("rst_busy", {busy2, busy5}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        // NBEAMS=2 frame: header timing and read latency
        done2 = 1'b1;
        @(negedge clk);
        done2 = 1'b0;
        check("t1_busy", busy2, 1);
        check("t1_first", {tvalid2, tdata2}, HDR ? {1'b1, 32'hBC000001} : 33'h0);
        repeat (2) begin
            @(negedge clk);
            check("t1_rd_early", rd2, 0);
        end
        @(negedge clk);
        check("t1_rd_first", {rd2, adr2}, {1'b1, 8'h00});
        if (HDR) e2.push_back({1'b0, 32'hBC000001});
        e2.push_back({1'b0, 32'h0ABC0123});
        e2.push_back({1'b1, 32'h00050FFF});
        n = 0;
        while (q2.size() < e2.size() && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check("t1_len", q2.size(), e2.size());
        for (int i = 0; i < e2.size() && i < q2.size(); i++) check("t1_word", q2[i], e2[i]);
        check("t1_busy_end", busy2, 0);
        // NBEAMS=5 frame with tready toggling
        pulse5();
        check("a_hdr", {tvalid5, tdata5}, HDR ? {1'b1, 32'hBC000001} : 33'h0);
        n = 0;
        while (m_active && n < 500) begin
            tready5 = ~tready5;
            @(negedge clk);
            n++;
        end
        tready5 = 1'b1;
        wait_idle("a");
        // overrun pulse during READ_HI
        pulse5();
        n = 0;
        while (!(rd5 && adr5[7]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b_reach_hi", {rd5, adr5}, {1'b1, 8'h80});
        pulse5();
        check("b_busy", busy5, 1);
        wait_idle("b");
        pulse5();
        check("c_hdr", {tvalid5, tdata5}, HDR ? {1'b1, 32'hBC010003} : 33'h0);
        wait_idle("c");
        // 300 overruns against a stalled frame
        tready5 = 1'b0;
        pulse5();
        repeat (20) @(negedge clk);
        check("d_stall_valid", {tvalid5, busy5}, 2'b11);
        repeat (300) begin
            pulse5();
            @(negedge clk);
        end
        tready5 = 1'b1;
        wait_idle("d");
        pulse5();
        check("e_hdr", {tvalid5, tdata5}, HDR ? {1'b1, 32'hBCFF0005} : 33'h0);
        wait_idle("e");
`ifdef BEAMSCALER_READOUT_HEADER_EN
        force u5.seq_q = 16'hFFFF;
        m_seq = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        release u5.seq_q;
        @(negedge clk);
`endif
        pulse5();
        check("f_hdr", {tvalid5, tdata5}, HDR ? {1'b1, 32'hBCFF0000} : 33'h0);
        wait_idle("f");
        // reset during READ_LO with output stalled
        tready5 = 1'b0;
        pulse5();
        n = 0;
        while (!(rd5 && !adr5[7]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("g_reach_lo", {rd5, adr5}, {1'b1, 8'h00});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("g_rst_tvalid", tvalid5, 0);
        check("g_rst_busy", busy5, 0);
        check("g_rst_rd", rd5, 0);
        tready5 = 1'b1;
        repeat (3) @(negedge clk);
        pulse5();
        check("g_hdr", {tvalid5, tdata5}, HDR ? {1'b1, 32'hBC000001} : 33'h0);
        wait_idle("g");
        check("g_len", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/beamscaler_readout.md
# beamscaler_readout

Streaming reader for the double-banked beam-scaler RAM. On each scaler-update completion pulse it waits for the bank swap to settle, then reads every real and subthreshold scaler word from the read port and emits one AXI4-Stream frame per update period with a header. It sits in the `wb_clk_i` domain between the beam-scaler block and the housekeeping/readout path, and removes the need for software to sync itself to the update period.

## Interface
Parameters:
- `NBEAMS`, 2: beams per bank; `NWORDS = (NBEAMS+1)/2` RAM words per half.
- `SETTLE`, 3: cycles from accepted `done_i` to the first RAM read (bank swap latency plus margin); range 1..15.
- `FIFO_DEPTH`, 4: output FIFO depth, power of 2, ≥ 4.

Ports (one clock `wb_clk_i`, synchronous active-high reset `wb_rst_i`):
- `wb_clk_i`  in  1  clock.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `done_i`  in  1  single-cycle update-complete pulse from the scaler block.
- `scal_rd_o`  out  1  RAM read enable.
- `scal_adr_o`  out  8  RAM word address; bank bit is supplied by the scaler block.
- `scal_dat_i`  in  32  RAM data, valid 2 cycles after `scal_rd_o`; beam 2k in [11:0], beam 2k+1 in [27:16].
- `m_axis_tdata`  out  32  stream data.
- `m_axis_tvalid`  out  1  stream valid.
- `m_axis_tready`  in  1  stream ready.
- `m_axis_tlast`  out  1  last word of frame.
- `busy_o`  out  1  frame in progress (state ≠ IDLE).

## Operation
- FSM: IDLE → SETTLE → READ_LO → READ_HI → DRAIN → IDLE.
- IDLE: `done_i` → SETTLE. Load settle counter with `SETTLE-1`. Increment `seq[15:0]`, which wraps at 0xFFFF→0. Push header `{8'hBC, ovr_cnt[7:0], seq_new[15:0]}`.
- SETTLE: count down; at 0 → READ_LO with address 0x00.
- READ_LO: issue reads at 0x00..NWORDS-1 → READ_HI.
- READ_HI: issue reads at 0x80..0x80+NWORDS-1 → DRAIN.
- Read issue rule: assert `scal_rd_o` only if `fifo_count + inflight < FIFO_DEPTH`. `inflight` counts reads whose data has not yet been captured (0..2). Captured data is pushed unmodified.
- The last subthreshold word is tagged `tlast` in the FIFO.
- DRAIN: wait until the FIFO is empty and no reads are in flight, then → IDLE.
- Overrun: `done_i` in any state other than IDLE increments `ovr_cnt`. `ovr_cnt` saturates at 0xFF and clears only on reset. The current frame continues unchanged; that `done_i` does not start a frame.
- Frame length: `2*NWORDS+1` words with header, `2*NWORDS` without.

## Timing
- Reset values: `scal_rd_o`=0, `scal_adr_o`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `busy_o`=0. `seq`=0, `ovr_cnt`=0, FIFO empty.
- Reset mid-frame: everything returns to the reset state in the next cycle. In-flight RAM data arriving afterwards is ignored.
- `done_i` at cycle t: `busy_o`=1 at t+1. Header `m_axis_tvalid` at t+1 (FIFO is show-ahead, registered output). First `scal_rd_o` at t+1+SETTLE.
- Read at cycle r: capture and FIFO push at r+2. The word is visible at the output at r+3 at the earliest.
- With `m_axis_tready` held high: one read per cycle and one word out per cycle. Stream is gap-free after the header/settle gap.
- AXI rules:
  - `tdata` and `tlast` hold stable while `tvalid & !tready`.
  - `tvalid` never drops without a handshake.
- FIFO push and pop in the same cycle: count unchanged.
- Full FIFO is never overrun; this is guaranteed by the credit rule.
- `done_i` coincident with reset: reset wins.

## Configuration
- `BEAMSCALER_READOUT_HEADER_EN` defined: the header word is emitted first, and `seq` and `ovr_cnt` are reported in it.
- Not defined: no header; the frame starts with word 0x00 and the first read is still at t+1+SETTLE. `seq` and `ovr_cnt` logic is removed.

## Structure
- Shared package `beamscaler_pkg`:
  - `BSR_HDR_MAGIC` = 8'hBC.
  - `BSR_SUBTHR_BASE` = 8'h80.
  - FSM state enum `bsr_state_t`.
  - Function `bsr_nwords(NBEAMS)`.
- One sub-module `bsr_sync_fifo`: 33-bit (tlast+data), show-ahead, `FIFO_DEPTH` entries, exposes `count`.

## Test plan
- NBEAMS=2, header on, tready=1: RAM[0x00]=0x0ABC0123, RAM[0x80]=0x00050FFF; `done_i` at t=10 → frame BC000001, 0ABC0123, 00050FFF. `tlast` on the third word. First `scal_rd_o` at t=14.
- NBEAMS=5 (NWORDS=3), tready toggling 1-0-1-0: addresses 00,01,02,80,81,82 read exactly once, in order. No dropped or duplicated word. FIFO count never exceeds 4.
- `done_i` pulsed during READ_HI, then a second frame: second header = BC010002. Busy frame unaffected.
- 300 `done_i` during frames: `ovr_cnt` saturates, header shows BCFF.
- `seq` at 0xFFFF, next frame: header seq = 0x0000.
- `wb_rst_i` asserted during READ_LO with tready=0: the next cycle has tvalid=0, busy_o=0, scal_rd_o=0. A subsequent `done_i` yields a clean frame with seq=0001 and exact length.
